// File: rtl/trigger_sequencer_if.sv
// Sample strobe / trigger input and buffer write bus between the capture front-end
// and the trigger sequencer.
interface trigger_sequencer_if #(
  parameter int NUM_TRIG   = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  sample_en;
  logic [NUM_TRIG-1:0]   trig_in;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (output sample_en, output trig_in, input wr_en, input wr_addr);
  modport slave  (input sample_en, input trig_in, output wr_en, output wr_addr);
endinterface

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: pre-trigger fill, sequential stage matching,
// post-trigger count and circular sample-buffer write addressing.
module trigger_sequencer #(
  parameter int NUM_TRIG   = 8,
  parameter int NUM_STAGE  = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  trigger_sequencer_if.slave              bus,
  input  logic [NUM_STAGE*NUM_TRIG-1:0]   stage_mask,
  input  logic [NUM_STAGE-1:0]            stage_and,
  input  logic [$clog2(NUM_STAGE)-1:0]    stage_last,
  input  logic [ADDR_WIDTH-1:0]           pre_depth,
  output logic                            busy,
  output logic                            triggered,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           trig_addr,
  output logic [ADDR_WIDTH-1:0]           start_addr,
  output logic [$clog2(NUM_STAGE)-1:0]    cur_stage
);
  localparam int SW = $clog2(NUM_STAGE);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [SW-1:0]         S_ONE = SW'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t                        state_reg, state_next;
  logic [ADDR_WIDTH-1:0]         wr_addr_reg, wr_addr_next;
  logic [ADDR_WIDTH-1:0]         trig_addr_reg, trig_addr_next;
  logic [ADDR_WIDTH-1:0]         start_addr_reg, start_addr_next;
  logic [SW-1:0]                 cur_stage_reg, cur_stage_next;
  logic                          triggered_reg, triggered_next;
  logic [ADDR_WIDTH-1:0]         pre_cnt_reg, pre_cnt_next;
  logic [ADDR_WIDTH-1:0]         post_cnt_reg, post_cnt_next;
  logic [NUM_STAGE*NUM_TRIG-1:0] mask_reg, mask_next;
  logic [NUM_STAGE-1:0]          and_reg, and_next;
  logic [SW-1:0]                 last_reg, last_next;
  logic [ADDR_WIDTH-1:0]         pre_depth_reg, pre_depth_next;

  logic [NUM_STAGE-1:0] stage_hit;
  logic                 cur_hit;

  // An empty mask matches unconditionally in both AND and OR mode.
  for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
    logic [NUM_TRIG-1:0] sel_mask;
    logic [NUM_TRIG-1:0] masked;
    assign sel_mask      = mask_reg[gi*NUM_TRIG +: NUM_TRIG];
    assign masked        = bus.trig_in & sel_mask;
    assign stage_hit[gi] = and_reg[gi] ? (masked == sel_mask)
                                       : ((|masked) || (sel_mask == '0));
  end

  assign cur_hit = stage_hit[cur_stage_reg];

  assign busy       = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
  assign done       = (state_reg == S_DONE);
  assign triggered  = triggered_reg;
  assign trig_addr  = trig_addr_reg;
  assign start_addr = start_addr_reg;
  assign cur_stage  = cur_stage_reg;
  assign bus.wr_en   = bus.sample_en & busy;
  assign bus.wr_addr = wr_addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wr_addr_reg    <= '0;
      trig_addr_reg  <= '0;
      start_addr_reg <= '0;
      cur_stage_reg  <= '0;
      triggered_reg  <= 1'b0;
      pre_cnt_reg    <= '0;
      post_cnt_reg   <= '0;
      mask_reg       <= '0;
      and_reg        <= '0;
      last_reg       <= '0;
      pre_depth_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      wr_addr_reg    <= wr_addr_next;
      trig_addr_reg  <= trig_addr_next;
      start_addr_reg <= start_addr_next;
      cur_stage_reg  <= cur_stage_next;
      triggered_reg  <= triggered_next;
      pre_cnt_reg    <= pre_cnt_next;
      post_cnt_reg   <= post_cnt_next;
      mask_reg       <= mask_next;
      and_reg        <= and_next;
      last_reg       <= last_next;
      pre_depth_reg  <= pre_depth_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_addr_next    = wr_addr_reg;
    trig_addr_next  = trig_addr_reg;
    start_addr_next = start_addr_reg;
    cur_stage_next  = cur_stage_reg;
    triggered_next  = triggered_reg;
    pre_cnt_next    = pre_cnt_reg;
    post_cnt_next   = post_cnt_reg;
    mask_next       = mask_reg;
    and_next        = and_reg;
    last_next       = last_reg;
    pre_depth_next  = pre_depth_reg;

    if (abort) begin
      // Addresses are kept so a cancelled capture can still be inspected.
      state_next     = S_IDLE;
      cur_stage_next = '0;
      triggered_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            mask_next      = stage_mask;
            and_next       = stage_and;
            last_next      = stage_last;
            pre_depth_next = pre_depth;
            wr_addr_next   = '0;
            cur_stage_next = '0;
            triggered_next = 1'b0;
            pre_cnt_next   = '0;
            state_next     = (pre_depth == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (bus.sample_en) begin
            wr_addr_next = wr_addr_reg + A_ONE;
            pre_cnt_next = pre_cnt_reg + A_ONE;
            if (pre_cnt_reg + A_ONE == pre_depth_reg) state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.sample_en) begin
            wr_addr_next = wr_addr_reg + A_ONE;
            if (cur_hit) begin
              if (cur_stage_reg == last_reg) begin
                triggered_next  = 1'b1;
                trig_addr_next  = wr_addr_reg;
                start_addr_next = wr_addr_reg - pre_depth_reg;
                post_cnt_next   = A_MAX - pre_depth_reg;
                state_next      = (pre_depth_reg == A_MAX) ? S_DONE : S_POST;
              end else begin
                cur_stage_next = cur_stage_reg + S_ONE;
              end
            end
          end
        end
        S_POST: begin
          if (bus.sample_en) begin
            wr_addr_next  = wr_addr_reg + A_ONE;
            post_cnt_next = post_cnt_reg - A_ONE;
            if (post_cnt_reg == A_ONE) state_next = S_DONE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized scoreboard bench for trigger_sequencer plus directed stage/abort/reset cases.
module tb_trigger_sequencer;
  localparam int NT = 4;
  localparam int NS = 4;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int TL = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS*NT-1:0] stage_mask = '0;
  logic [NS-1:0] stage_and = '0;
  logic [1:0]    stage_last = '0;
  logic [AW-1:0] pre_depth = '0;
  logic          busy, triggered, done;
  logic [AW-1:0] trig_addr, start_addr;
  logic [1:0]    cur_stage;

  trigger_sequencer_if #(.NUM_TRIG(NT), .ADDR_WIDTH(AW)) bus ();

  trigger_sequencer #(.NUM_TRIG(NT), .NUM_STAGE(NS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .stage_mask(stage_mask), .stage_and(stage_and), .stage_last(stage_last),
    .pre_depth(pre_depth), .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr), .cur_stage(cur_stage)
  );

  always #5 clk = ~clk;

  typedef struct { int ta; int sa; int fa; } exp_t;
  int   wq[$];
  exp_t dq[$];
  int   checks = 0;
  int   errors = 0;
  logic sb_on = 1'b0;
  logic done_q = 1'b0;
  int   tlist [TL];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_hit(input int trig, input int mask, input bit and_mode);
    if (mask == 0) return 1'b1;
    if (and_mode) return (trig & mask) == mask;
    return (trig & mask) != 0;
  endfunction

  // Scoreboard monitor: every buffer write and every capture completion pops an expectation.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (bus.wr_en) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("wr_addr", bus.wr_addr, wq.pop_front());
      end
      if (done && !done_q) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = dq.pop_front();
          chk("trig_addr", trig_addr, e.ta);
          chk("start_addr", start_addr, e.sa);
          chk("final_wr_addr", bus.wr_addr, e.fa);
          chk("triggered_at_done", triggered, 1);
          chk("busy_at_done", busy, 0);
        end
      end
    end
    done_q <= done;
  end

  task automatic step(input logic se, input logic [NT-1:0] t);
    bus.sample_en = se;
    bus.trig_in   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int pre, input logic [NS*NT-1:0] m, input logic [NS-1:0] a, input int last);
    pre_depth  = AW'(pre);
    stage_mask = m;
    stage_and  = a;
    stage_last = 2'(last);
    start      = 1'b1;
    step(1'b1, NT'($urandom));
    start      = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step(1'b0, '0);
    abort = 1'b0;
  endtask

  // Model a whole capture from the stage rules, queue its writes and result, then play it.
  task automatic run_capture(input int pre, input logic [NS*NT-1:0] m, input logic [NS-1:0] a,
                             input int last, input int period, input logic [NT-1:0] ns_trig);
    int t, s, total, k, cyc;
    t = -1;
    s = 0;
    for (int i = pre; i < TL; i++) begin
      if (ref_hit(tlist[i], int'(m[s*NT +: NT]), a[s])) begin
        if (s == last) begin t = i; break; end
        s++;
      end
    end
    total = t + 1 + (D - 1 - pre);
    wq.delete();
    dq.delete();
    for (int i = 0; i < total; i++) wq.push_back(i % D);
    dq.push_back('{ta: t % D, sa: (t - pre + D) % D, fa: total % D});
    $display("capture pre=%0d last=%0d period=%0d trigger_strobe=%0d writes=%0d",
             pre, last, period, t, total);
    sb_on = 1'b1;
    do_start(pre, m, a, last);
    // Config inputs are scrambled after start; the latched copy must be used.
    stage_mask = NS*NT'($urandom);
    stage_and  = NS'($urandom);
    stage_last = 2'($urandom);
    pre_depth  = AW'($urandom);
    k = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (done) break;
      if (cyc % period == 0) step(1'b1, NT'(tlist[k++]));
      else step(1'b0, ns_trig);
    end
    chk("capture_done", done, 1);
    bus.sample_en = 1'b0;
    @(posedge clk);
    #1;
    chk("writes_left", wq.size(), 0);
    chk("results_left", dq.size(), 0);
    sb_on = 1'b0;
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.trig_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_cur_stage", cur_stage, 0);
    rst = 1'b0;
    step(1'b0, '0);

    // Single OR stage, pre 4, trigger on the 10th strobe.
    for (int i = 0; i < TL; i++) tlist[i] = (i == 9) ? 4'b0010 : 0;
    run_capture(4, 16'h0002, 4'b0000, 0, 1, 4'h0);

    // Strobe every 3rd cycle, trigger pattern present only between strobes.
    for (int i = 0; i < TL; i++) tlist[i] = (i == 12) ? 4'b0001 : 0;
    run_capture(5, 16'h0001, 4'b0000, 0, 3, 4'hF);

    // Randomized captures, including both pre_depth extremes.
    for (int n = 0; n < 12; n++) begin
      int pre;
      pre = (n == 0) ? 0 : (n == 1) ? 15 : $urandom_range(0, 15);
      for (int i = 0; i < TL; i++) tlist[i] = (i >= 200) ? 15 : $urandom_range(0, 15);
      run_capture(pre, NS*NT'($urandom), NS'($urandom), $urandom_range(0, 3),
                  $urandom_range(1, 3), NT'($urandom));
    end

    // Three sequential OR stages, then abort in POST.
    do_start(0, 16'h0421, 4'b0000, 2);
    step(1'b1, 4'b0010); chk("seq_stage_a", cur_stage, 0);
    step(1'b1, 4'b0001); chk("seq_stage_b", cur_stage, 1);
    step(1'b1, 4'b0100); chk("seq_stage_c", cur_stage, 1);
    step(1'b1, 4'b0010); chk("seq_stage_d", cur_stage, 2);
    step(1'b1, 4'b0100);
    chk("seq_triggered", triggered, 1);
    chk("seq_trig_addr", trig_addr, 4);
    chk("seq_post_busy", busy, 1);
    step(1'b1, 4'b0000);
    do_abort();
    bus.sample_en = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_triggered", triggered, 0);
    chk("abort_cur_stage", cur_stage, 0);
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_wr_addr_hold", bus.wr_addr, 6);
    chk("abort_trig_addr_hold", trig_addr, 4);
    $display("directed three-stage sequence and abort in POST");

    // One strobe hitting stages 0 and 1 advances a single stage.
    do_start(0, 16'h0421, 4'b0000, 2);
    step(1'b1, 4'b0011); chk("one_stage_per_strobe", cur_stage, 1);
    do_abort();

    // start and abort together.
    start = 1'b1;
    abort = 1'b1;
    step(1'b1, 4'b0000);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    $display("directed start with abort");

    // AND stage 0 on mask 0011, then an empty-mask stage 1.
    do_start(0, 16'h0003, 4'b0001, 1);
    step(1'b1, 4'b0001); chk("and_partial", cur_stage, 0);
    step(1'b1, 4'b0011); chk("and_full", cur_stage, 1);
    step(1'b1, 4'b0000); chk("empty_mask_hit", triggered, 1);
    do_abort();
    $display("directed AND mode and empty mask");

    // Asynchronous reset in WAIT.
    do_start(0, 16'h000F, 4'b0001, 0);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    chk("wait_wr_addr", bus.wr_addr, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_wr_addr", bus.wr_addr, 0);
    chk("arst_cur_stage", cur_stage, 0);
    chk("arst_triggered", triggered, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.sample_en = 1'b0;
    $display("directed asynchronous reset in WAIT");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Multi-stage trigger controller for the logic analyzer capture path. It takes the trig outputs of the per-channel basic trigger comparators and runs up to NUM_STAGE sequential match stages. It also controls pre-trigger fill, post-trigger count and circular write addressing of the sample buffer, and reports the trigger position to the readout logic.

Parameters:
NUM_TRIG, 8, number of basic trigger inputs
NUM_STAGE, 4, number of sequence stages (power of 2, ≥2)
ADDR_WIDTH, 12, sample buffer address width; depth D = 2^ADDR_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  arm pulse; accepted only in IDLE or DONE
abort  in  1  cancel pulse; any state → IDLE
sample_en  in  1  sample strobe; trig_in and sample data are valid this cycle
trig_in  in  NUM_TRIG  basic trigger results
stage_mask  in  NUM_STAGE*NUM_TRIG  per-stage input select; stage s = bits [s*NUM_TRIG +: NUM_TRIG]
stage_and  in  NUM_STAGE  per-stage combine: 1 = AND of selected, 0 = OR
stage_last  in  log2(NUM_STAGE)  index of final stage
pre_depth  in  ADDR_WIDTH  pre-trigger sample count
wr_en  out  1  buffer write enable
wr_addr  out  ADDR_WIDTH  buffer write address
busy  out  1  state is PRE, WAIT or POST
triggered  out  1  final stage matched
done  out  1  capture complete
trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample
start_addr  out  ADDR_WIDTH  oldest valid sample = trig_addr − pre_depth (mod D)
cur_stage  out  log2(NUM_STAGE)  stage currently being evaluated

Behaviour:
- Reset: state IDLE. wr_addr, trig_addr, start_addr, cur_stage, all counters and all config latches are 0. triggered and done are 0.
- Config latch: on an accepted start, stage_mask, stage_and, stage_last and pre_depth are registered. Changes to these inputs while busy have no effect.
- wr_en = sample_en & busy. This is combinational from the registered state, so there is zero latency.
- Each write increments wr_addr at the next edge, wrapping D−1 → 0.
- Stage hit: m = trig_in & mask_s.
  - AND mode: hit = (m == mask_s).
  - OR mode: hit = |m.
  - mask_s == 0 gives hit = 1 in both modes.
- Hits are evaluated only on sample_en cycles.
- IDLE/DONE + start (abort low):
  - Clear wr_addr, cur_stage, triggered, done and the pre counter.
  - Next state is PRE, or WAIT if pre_depth == 0.
  - A sample_en in the start cycle is not written.
- PRE: each strobe writes and increments pre_cnt. Transition to WAIT at the edge where the write count reaches pre_depth, i.e. after exactly pre_depth writes. Stages are not evaluated in PRE.
- WAIT: each strobe writes; the buffer wraps freely. On a strobe with cur_stage hit:
  - If cur_stage < stage_last: cur_stage+1. At most one stage advances per strobe.
  - If cur_stage == stage_last: set triggered = 1, trig_addr = wr_addr of this sample, and start_addr = wr_addr − pre_depth.
    - post_cnt = D−1−pre_depth.
    - If post_cnt == 0, go to DONE; otherwise go to POST.
- POST: each strobe writes and decrements post_cnt. The edge at which post_cnt reaches 0 goes to DONE. Final wr_addr equals start_addr.
- DONE: done = 1, busy = 0, wr_en = 0. triggered and addresses hold until the next start or abort.
- abort: from any state, the next edge goes to IDLE and clears busy, done, triggered and cur_stage. wr_addr, trig_addr and start_addr hold. abort wins over a simultaneous start.
- start while busy is ignored.
- rst asserted in any state forces reset values immediately, without waiting for clk.

Test Plan:
- ADDR_WIDTH=4, NUM_TRIG=4, NUM_STAGE=4, stage_last=0, stage 0 OR mask 4'b0010, pre_depth=4, sample_en=1. Pulse trig_in[1] on the 10th strobe after start → expected response:
  - WAIT entered after 4 writes.
  - triggered=1, trig_addr=9, start_addr=5.
  - 11 further writes, then done=1 with wr_addr=5.
- Three stages (stage_last=2): stage 0 = trig[0] OR, stage 1 = trig[1] OR, stage 2 = trig[2] OR. Drive sequence trig[1], trig[0], trig[2], trig[1], trig[2] → expected cur_stage 0, 1, 1, 2, then triggered. A strobe hitting stages 0 and 1 together advances only to stage 1.
- AND mode, mask 4'b0011: trig_in=4'b0001 → no hit; trig_in=4'b0011 → hit. mask 0 → hit on the first WAIT strobe.
- Boundaries:
  - pre_depth=0: start goes straight to WAIT; 15 post writes.
  - pre_depth=15: trigger goes to DONE at the next edge with 0 post writes.
- sample_en every 3rd cycle with trig_in high only on non-strobe cycles → no stage advance. Pre/post counts advance only on strobes.
- abort mid-POST → IDLE next edge, busy=done=triggered=0, wr_en=0 despite sample_en. start+abort together → IDLE. rst mid-WAIT → all outputs 0 asynchronously.
